// File: rtl/block_360_ledout.sv
// block_360_ledout: ping-pong zone buffer with global brightness scaling and
// SCLK/SDO/LAT serialisation of one frame of zone words to a MiniLED driver chain.
module block_360_ledout #(
  parameter int unsigned ZONES      = 360,
  parameter int unsigned DW         = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned LAT_CYCLES = 2
) (
  input  logic          i_pix_clk,
  input  logic          rst,
  input  logic [8:0]    zone_idx,
  input  logic          zone_valid,
  input  logic [DW-1:0] zone_value,
  input  logic          vsync,
  input  logic [7:0]    brightness,
  output logic          led_sclk,
  output logic          led_sdo,
  output logic          led_lat,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int unsigned AW  = $clog2(2 * ZONES);
  localparam int unsigned WW  = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned DVW = $clog2(2 * CLK_DIV);
  localparam int unsigned BW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned LW  = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
  localparam int unsigned PW  = DW + 9;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  mem [2*ZONES];
  logic [DW-1:0]  rd_data;
  logic           vsync_q, vs_edge;
  logic           wr_bank, wr_bank_nxt;
  logic           rd_bank, rd_bank_nxt;
  logic [7:0]     bright_q, bright_nxt;
  logic           load_ph, load_ph_nxt;
  logic [WW-1:0]  word_idx, word_nxt;
  logic [BW-1:0]  bit_cnt, bit_nxt;
  logic [DVW-1:0] div_cnt, div_nxt;
  logic [LW-1:0]  lat_cnt, lat_nxt;
  logic [DW-1:0]  shreg, shreg_nxt;
  logic [PW-1:0]  product;
  logic [DW-1:0]  scaled;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic           wr_en;
  logic           sclk_d, sdo_d, lat_d, busy_d, done_d, overrun_d;

  assign vs_edge = vsync & ~vsync_q;
  assign wr_en   = zone_valid && (32'(zone_idx) < ZONES);
  assign wr_addr = AW'(zone_idx) + (wr_bank ? AW'(ZONES) : AW'(0));
  assign rd_addr = AW'(word_idx) + (rd_bank ? AW'(ZONES) : AW'(0));
  assign product = PW'(rd_data) * (PW'(bright_q) + PW'(1));
  assign scaled  = DW'(product >> 8);

  // Zone buffer: write port on the fill bank, synchronous read in the first LOAD cycle.
  always_ff @(posedge i_pix_clk) begin
    if (wr_en) mem[wr_addr] <= zone_value;
    if (state == LOAD && !load_ph) rd_data <= mem[rd_addr];
  end

  // State, datapath and registered-output update.
  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      bright_q   <= '0;
      load_ph    <= 1'b0;
      word_idx   <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      lat_cnt    <= '0;
      shreg      <= '0;
      led_sclk   <= 1'b0;
      led_sdo    <= 1'b0;
      led_lat    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      vsync_q    <= vsync;
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      bright_q   <= bright_nxt;
      load_ph    <= load_ph_nxt;
      word_idx   <= word_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      lat_cnt    <= lat_nxt;
      shreg      <= shreg_nxt;
      led_sclk   <= sclk_d;
      led_sdo    <= sdo_d;
      led_lat    <= lat_d;
      busy       <= busy_d;
      frame_done <= done_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state and counter sequencing: swap on frame edge, load/shift each word, latch at end.
  always_comb begin
    state_nxt   = state;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    bright_nxt  = bright_q;
    load_ph_nxt = load_ph;
    word_nxt    = word_idx;
    bit_nxt     = bit_cnt;
    div_nxt     = div_cnt;
    lat_nxt     = lat_cnt;
    shreg_nxt   = shreg;
    case (state)
      IDLE: begin
        if (vs_edge) begin
          rd_bank_nxt = wr_bank;
          wr_bank_nxt = ~wr_bank;
          bright_nxt  = brightness;
          word_nxt    = '0;
          load_ph_nxt = 1'b0;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        if (!load_ph) begin
          load_ph_nxt = 1'b1;
        end else begin
          load_ph_nxt = 1'b0;
          shreg_nxt   = scaled;
          bit_nxt     = BW'(DW - 1);
          div_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DVW'(2 * CLK_DIV - 1)) begin
          div_nxt = '0;
          if (bit_cnt == '0) begin
            if (word_idx == WW'(ZONES - 1)) begin
              lat_nxt   = '0;
              state_nxt = LATCH;
            end else begin
              word_nxt  = word_idx + WW'(1);
              state_nxt = LOAD;
            end
          end else begin
            shreg_nxt = {shreg[DW-2:0], 1'b0};
            bit_nxt   = bit_cnt - BW'(1);
          end
        end else begin
          div_nxt = div_cnt + DVW'(1);
        end
      end
      LATCH: begin
        if (lat_cnt == LW'(LAT_CYCLES - 1)) begin
          state_nxt = IDLE;
        end else begin
          lat_nxt = lat_cnt + LW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from next-state values so registered outputs line up with the state.
  always_comb begin
    sclk_d    = 1'b0;
    sdo_d     = 1'b0;
    lat_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    busy_d    = (state_nxt != IDLE);
    lat_d     = (state_nxt == LATCH);
    if (state_nxt == SHIFT) begin
      sclk_d = (div_nxt >= DVW'(CLK_DIV));
      sdo_d  = shreg_nxt[DW-1];
    end
    done_d    = (state == LATCH) && (state_nxt == IDLE);
    overrun_d = vs_edge && (state != IDLE);
  end

endmodule

// File: tb/tb_block_360_ledout.sv
// Scoreboard bench for block_360_ledout: stimulus queues expected serial words,
// negedge monitors deserialise SCLK/SDO and compare; a small instance checks timing.
module tb_block_360_ledout;

  localparam int ZN        = 360;
  localparam int CDIV      = 2;
  localparam int LATC      = 2;
  localparam int FRAME_LEN = ZN * (2 + 8 * 2 * CDIV) + LATC;
  localparam int S_LEN     = 4 * (2 + 8 * 2 * 1) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] zone_idx;
  logic       zone_valid;
  logic [7:0] zone_value;
  logic       vsync;
  logic [7:0] brightness;
  logic       led_sclk, led_sdo, led_lat, busy, frame_done, overrun;

  logic [8:0] s_zone_idx;
  logic       s_zone_valid;
  logic [7:0] s_zone_value;
  logic       s_vsync;
  logic [7:0] s_brightness;
  logic       s_sclk, s_sdo, s_lat, s_busy, s_done, s_overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] s_exp_q[$];

  int words_rx = 0, done_cnt = 0, ovr_cnt = 0;
  int bit_n = 0, hi_run = 0, busy_run = 0, lat_run = 0;
  logic [7:0] shw = '0;
  logic [7:0] e_word;
  logic cur_bit = 1'b0, p_sclk = 1'b0, p_busy = 1'b0, p_lat = 1'b0;

  int s_bit_n = 0, s_hi_run = 0, s_busy_run = 0, s_lat_run = 0, s_done_cnt = 0;
  logic [7:0] s_shw = '0;
  logic [7:0] s_e_word;
  logic s_p_sclk = 1'b0, s_p_busy = 1'b0, s_p_lat = 1'b0;

  always #5 clk = ~clk;

  block_360_ledout #(.ZONES(ZN), .DW(8), .CLK_DIV(CDIV), .LAT_CYCLES(LATC)) u_dut (
    .i_pix_clk(clk), .rst(rst), .zone_idx(zone_idx), .zone_valid(zone_valid),
    .zone_value(zone_value), .vsync(vsync), .brightness(brightness),
    .led_sclk(led_sclk), .led_sdo(led_sdo), .led_lat(led_lat), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  block_360_ledout #(.ZONES(4), .DW(8), .CLK_DIV(1), .LAT_CYCLES(1)) u_small (
    .i_pix_clk(clk), .rst(rst), .zone_idx(s_zone_idx), .zone_valid(s_zone_valid),
    .zone_value(s_zone_value), .vsync(s_vsync), .brightness(s_brightness),
    .led_sclk(s_sclk), .led_sdo(s_sdo), .led_lat(s_lat), .busy(s_busy),
    .frame_done(s_done), .overrun(s_overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main monitor: deserialise words on SCLK rise and check framing timing.
  always @(negedge clk) begin
    if (rst) begin
      bit_n = 0; hi_run = 0; busy_run = 0; lat_run = 0;
      p_sclk = 1'b0; p_busy = 1'b0; p_lat = 1'b0;
    end else begin
      if (led_sclk && !p_sclk) begin
        cur_bit = led_sdo;
        shw = {shw[6:0], led_sdo};
        bit_n++;
        if (bit_n == 8) begin
          bit_n = 0;
          words_rx++;
          if (exp_q.size() == 0) chk("word_extra", 1, 0);
          else begin
            e_word = exp_q.pop_front();
            chk("word", int'(shw), int'(e_word));
          end
        end
      end else if (led_sclk && p_sclk) begin
        chk("sdo_stable", int'(led_sdo), int'(cur_bit));
      end
      if (led_sclk) hi_run++;
      else begin
        if (p_sclk) chk("sclk_high_len", hi_run, CDIV);
        hi_run = 0;
      end
      if (busy) busy_run++;
      else begin
        if (p_busy) chk("busy_len", busy_run, FRAME_LEN);
        busy_run = 0;
      end
      if (led_lat) begin
        lat_run++;
        chk("lat_quiet", int'({led_sclk, led_sdo}), 0);
      end else begin
        if (p_lat) chk("lat_len", lat_run, LATC);
        lat_run = 0;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_busy", int'({p_busy, busy}), 2);
      end
      if (overrun) ovr_cnt++;
      p_sclk = led_sclk; p_busy = busy; p_lat = led_lat;
    end
  end

  // Small-instance monitor: CLK_DIV=1, LAT_CYCLES=1, four zones.
  always @(negedge clk) begin
    if (rst) begin
      s_bit_n = 0; s_hi_run = 0; s_busy_run = 0; s_lat_run = 0;
      s_p_sclk = 1'b0; s_p_busy = 1'b0; s_p_lat = 1'b0;
    end else begin
      if (s_sclk && !s_p_sclk) begin
        s_shw = {s_shw[6:0], s_sdo};
        s_bit_n++;
        if (s_bit_n == 8) begin
          s_bit_n = 0;
          if (s_exp_q.size() == 0) chk("s_word_extra", 1, 0);
          else begin
            s_e_word = s_exp_q.pop_front();
            chk("s_word", int'(s_shw), int'(s_e_word));
          end
        end
      end
      if (s_sclk) s_hi_run++;
      else begin
        if (s_p_sclk) chk("s_sclk_high_len", s_hi_run, 1);
        s_hi_run = 0;
      end
      if (s_busy) s_busy_run++;
      else begin
        if (s_p_busy) chk("s_busy_len", s_busy_run, S_LEN);
        s_busy_run = 0;
      end
      if (s_lat) s_lat_run++;
      else begin
        if (s_p_lat) chk("s_lat_len", s_lat_run, 1);
        s_lat_run = 0;
      end
      if (s_done) s_done_cnt++;
      s_p_sclk = s_sclk; s_p_busy = s_busy; s_p_lat = s_lat;
    end
  end

  task automatic wr(input int idx, input int val);
    zone_idx = 9'(idx); zone_value = 8'(val); zone_valid = 1'b1;
    @(posedge clk); #1;
    zone_valid = 1'b0;
  endtask

  task automatic start_frame(input int b);
    brightness = 8'(b); vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    chk("frame_done_count", done_cnt, target);
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_rx < target && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    if (n >= budget) chk("timeout_words", words_rx, target);
  endtask

  task automatic end_checks(input int exp_ovr);
    chk("queue_empty", exp_q.size(), 0);
    chk("overrun_count", ovr_cnt, exp_ovr);
  endtask

  initial begin
    int wb;
    int dc;
    logic [7:0] sv[4];
    rst = 1'b1; vsync = 1'b0; zone_valid = 1'b0; zone_idx = '0; zone_value = '0; brightness = '0;
    s_vsync = 1'b0; s_zone_valid = 1'b0; s_zone_idx = '0; s_zone_value = '0; s_brightness = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({led_sclk, led_sdo, led_lat, busy, frame_done, overrun}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("idle_outputs", int'({led_sclk, led_sdo, led_lat, busy}), 0);

    // Identity brightness, value = zone index.
    for (int i = 0; i < ZN; i++) wr(i, i);
    for (int i = 0; i < ZN; i++) exp_q.push_back(8'(i));
    start_frame(255);
    wait_done(1, FRAME_LEN + 100);
    end_checks(0);

    // brightness 127 halves 200 to 100.
    for (int i = 0; i < ZN; i++) wr(i, 200);
    for (int i = 0; i < ZN; i++) exp_q.push_back(8'd100);
    start_frame(127);
    wait_done(2, FRAME_LEN + 100);
    end_checks(0);

    // Out-of-range writes, write coincident with swap, overrun mid-frame.
    for (int i = 0; i < ZN; i++) wr(i, i * 3);
    wr(360, 8'h11);
    wr(511, 8'h22);
    for (int i = 0; i < ZN; i++) exp_q.push_back((i == 7) ? 8'hC3 : 8'(i * 3));
    wb = words_rx;
    zone_idx = 9'd7; zone_value = 8'hC3; zone_valid = 1'b1;
    brightness = 8'd255; vsync = 1'b1;
    @(posedge clk); #1;
    zone_valid = 1'b0; vsync = 1'b0;
    for (int i = 0; i < ZN; i++) if (i != 0 && i != 151) wr(i, i ^ 8'h5A);
    wait_words(wb + 100, 100 * 40 + 200);
    start_frame(255);
    repeat (3) @(posedge clk); #1;
    chk("overrun_pulse", ovr_cnt, 1);
    chk("busy_during_overrun", int'(busy), 1);
    wr(5, 8'hAA);
    wait_done(3, FRAME_LEN + 100);
    end_checks(1);

    // Next frame sends the bank filled since the first swap.
    for (int i = 0; i < ZN; i++) begin
      if (i == 0 || i == 151) exp_q.push_back(8'd200);
      else if (i == 5) exp_q.push_back(8'hAA);
      else exp_q.push_back(8'(i ^ 8'h5A));
    end
    start_frame(255);
    wait_done(4, FRAME_LEN + 100);
    end_checks(1);

    // Abort with reset during word 37.
    for (int i = 0; i < ZN; i++) wr(i, 255 - i);
    for (int i = 0; i < ZN; i++) exp_q.push_back(8'(255 - i));
    wb = words_rx;
    start_frame(255);
    wait_words(wb + 37, 37 * 40 + 200);
    chk("words_before_abort", words_rx - wb, 37);
    repeat (6) @(posedge clk); #1;
    chk("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("reset_async_outputs", int'({busy, led_sclk, led_sdo, led_lat}), 0);
    exp_q.delete();
    dc = done_cnt;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("no_done_after_abort", done_cnt, dc);
    chk("idle_after_abort", int'(busy), 0);

    // Clean restart with brightness 0: every word is zero.
    for (int i = 0; i < ZN; i++) exp_q.push_back(8'd0);
    start_frame(0);
    wait_done(dc + 1, FRAME_LEN + 100);
    end_checks(1);

    // Small configuration: 73-cycle frame, 2-cycle SCLK period.
    sv[0] = 8'h81; sv[1] = 8'h42; sv[2] = 8'h18; sv[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      s_zone_idx = 9'(i); s_zone_value = sv[i]; s_zone_valid = 1'b1;
      @(posedge clk); #1;
      s_zone_valid = 1'b0;
      s_exp_q.push_back(sv[i]);
    end
    s_brightness = 8'd255; s_vsync = 1'b1;
    @(posedge clk); #1;
    s_vsync = 1'b0;
    for (int n = 0; n < S_LEN + 50 && s_done_cnt == 0; n++) @(posedge clk);
    #1;
    chk("s_frame_done_count", s_done_cnt, 1);
    chk("s_queue_empty", s_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
